// File: rtl/carga_serie_operandos_pkg.sv
// Shared definitions for the serial operand loader: FSM encodings and sizing helpers.
package carga_serie_operandos_pkg;

  typedef enum logic [1:0] {
    ST_LOAD_A  = 2'd0,
    ST_LOAD_B  = 2'd1,
    ST_PRESENT = 2'd2
  } estado_t;

  localparam int WIDTH_DEF = 4;

  // Bit counter width; kept at least 1 so a 1-bit operand still has a legal counter.
  function automatic int cnt_w(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/carga_serie_operandos_registro.sv
// Serial-in, parallel-out shift register with load enable; bit order set by MSB_FIRST.
module registro_serie #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             din,
  output logic [WIDTH-1:0] q
);

  generate
    if (WIDTH == 1) begin : g_one
      always_ff @(posedge clk or posedge rst)
        if (rst)     q <= '0;
        else if (en) q <= din;
    end else if (MSB_FIRST) begin : g_msb
      always_ff @(posedge clk or posedge rst)
        if (rst)     q <= '0;
        else if (en) q <= {q[WIDTH-2:0], din};
    end else begin : g_lsb
      always_ff @(posedge clk or posedge rst)
        if (rst)     q <= '0;
        else if (en) q <= {din, q[WIDTH-1:1]};
    end
  endgenerate

endmodule

// File: rtl/carga_serie_operandos.sv
// Assembles two serial operands for the ripple adder, presents them, and registers the adder's sum.
module carga_serie_operandos
  import carga_serie_operandos_pkg::*;
#(
  parameter int WIDTH     = WIDTH_DEF,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             op_valid,
  input  logic             op_ack,
  input  logic [WIDTH:0]   sum_in,
  output logic [WIDTH:0]   result,
  output logic             result_valid
);

  localparam int             CW       = cnt_w(WIDTH);
  localparam logic [CW-1:0]  CNT_LAST = CW'(WIDTH - 1);

  estado_t       st, st_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          xfer, ld_a, ld_b, take;

  assign xfer = ser_valid & ser_ready;
  assign ld_a = xfer & (st == ST_LOAD_A);
  assign ld_b = xfer & (st == ST_LOAD_B);
  assign take = op_valid & op_ack;

  always_comb begin
    st_nxt  = st;
    cnt_nxt = cnt;
    case (st)
      ST_LOAD_A, ST_LOAD_B:
        if (xfer) begin
          if (cnt == CNT_LAST) begin
            cnt_nxt = '0;
            st_nxt  = (st == ST_LOAD_A) ? ST_LOAD_B : ST_PRESENT;
          end else begin
            cnt_nxt = cnt + CW'(1);
          end
        end
      ST_PRESENT:
        if (take) st_nxt = ST_LOAD_A;
      default: st_nxt = ST_LOAD_A;
    endcase
  end

  // Handshake flags are registered from the next state so they read 0 throughout reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st           <= ST_LOAD_A;
      cnt          <= '0;
      ser_ready    <= 1'b0;
      op_valid     <= 1'b0;
      result       <= '0;
      result_valid <= 1'b0;
    end else begin
      st           <= st_nxt;
      cnt          <= cnt_nxt;
      ser_ready    <= (st_nxt != ST_PRESENT);
      op_valid     <= (st_nxt == ST_PRESENT);
      result_valid <= take;
      if (take) result <= sum_in;
    end
  end

  registro_serie #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_reg_a (
    .clk(clk), .rst(rst), .en(ld_a), .din(ser_in), .q(a)
  );

  registro_serie #(.WIDTH(WIDTH), .MSB_FIRST(MSB_FIRST)) u_reg_b (
    .clk(clk), .rst(rst), .en(ld_b), .din(ser_in), .q(b)
  );

endmodule

// File: tb/tb_carga_serie_operandos.sv
// Directed bench for carga_serie_operandos; a behavioural adder closes the SUM_IN loop.
module tb_carga_serie_operandos;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ser_in = 1'b0;
  logic       ser_valid = 1'b0;
  logic       ser_ready;
  logic [3:0] a, b;
  logic       op_valid;
  logic       op_ack = 1'b0;
  logic [4:0] sum_in;
  logic [4:0] result;
  logic       result_valid;

  int n_chk  = 0;
  int n_fail = 0;

  carga_serie_operandos #(.WIDTH(4), .MSB_FIRST(1'b0)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_valid(ser_valid), .ser_ready(ser_ready),
    .a(a), .b(b), .op_valid(op_valid), .op_ack(op_ack), .sum_in(sum_in),
    .result(result), .result_valid(result_valid)
  );

  assign sum_in = {1'b0, a} + {1'b0, b};

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one bit and wait for the edge that accepts it; gap idle cycles precede it.
  task automatic send_bit(input logic v, input int gap);
    bit done;
    for (int g = 0; g < gap; g++) begin
      ser_valid = 1'b0;
      ser_in    = ~v;
      tick();
    end
    ser_valid = 1'b1;
    ser_in    = v;
    done      = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      if (ser_ready) done = 1'b1;
      tick();
    end
    if (!done) check("send_bit_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_word(input logic [3:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_bit(w[i], gap);
    ser_valid = 1'b0;
  endtask

  task automatic do_ack(input string tag, input logic [4:0] exp_r);
    op_ack = 1'b1;
    tick();
    op_ack = 1'b0;
    check({tag, "_rv"},     result_valid, 1);
    check({tag, "_result"}, result, exp_r);
    check({tag, "_ready"},  ser_ready, 1);
    check({tag, "_opv"},    op_valid, 0);
    tick();
    check({tag, "_rv_low"}, result_valid, 0);
    check({tag, "_hold"},   result, exp_r);
  endtask

  task automatic do_pair(input string tag, input logic [3:0] wa, input logic [3:0] wb,
                         input int gap, input logic [4:0] exp_r);
    send_word(wa, gap);
    send_word(wb, gap);
    check({tag, "_opv"},   op_valid, 1);
    check({tag, "_a"},     a, wa);
    check({tag, "_b"},     b, wb);
    check({tag, "_ready"}, ser_ready, 0);
    do_ack(tag, exp_r);
  endtask

  initial begin
    // Reset state
    tick(); tick();
    check("rst_ready", ser_ready, 0);
    check("rst_opv",   op_valid, 0);
    check("rst_res",   result, 0);
    check("rst_rv",    result_valid, 0);
    check("rst_a",     a, 0);
    rst = 1'b0;
    check("rel_ready_pre", ser_ready, 0);
    tick();
    check("rel_ready", ser_ready, 1);

    // Basic: bits 1,0,1,0 / 1,1,0,0 LSB first
    do_pair("basic", 4'h5, 4'h3, 0, 5'd8);
    // Carry out kept
    do_pair("carry1", 4'hF, 4'h1, 0, 5'h10);
    do_pair("carry2", 4'hF, 4'hF, 0, 5'h1E);
    // Sparse valid: one transfer every 3rd cycle
    do_pair("gaps", 4'h5, 4'h3, 2, 5'd8);

    // ACK raised while loading is ignored until operands are presented
    op_ack = 1'b1;
    send_word(4'h2, 0);
    check("early_rv",  result_valid, 0);
    check("early_res", result, 5'd8);
    op_ack = 1'b0;
    send_word(4'h4, 0);
    check("early_opv", op_valid, 1);
    do_ack("early", 5'd6);

    // Stall in PRESENT with serial activity
    send_word(4'h6, 0);
    send_word(4'h9, 0);
    for (int i = 0; i < 10; i++) begin
      ser_valid = i[0];
      ser_in    = ~i[1];
      tick();
      check("stall_ready", ser_ready, 0);
      check("stall_ab", {a, b}, 8'h69);
    end
    ser_valid = 1'b0;
    check("stall_opv", op_valid, 1);
    check("stall_rv",  result_valid, 0);
    do_ack("stall", 5'h0F);

    // Reset after 6 bits discards the partial load
    send_word(4'hF, 0);
    send_bit(1'b1, 0);
    send_bit(1'b1, 0);
    ser_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_ready", ser_ready, 0);
    check("mid_a",     a, 0);
    check("mid_b",     b, 0);
    check("mid_res",   result, 0);
    tick();
    check("mid_rv",    result_valid, 0);
    rst = 1'b0;
    tick();
    check("mid_rel_ready", ser_ready, 1);
    do_pair("fresh", 4'h9, 4'h7, 0, 5'h10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
